// File: rtl/decode_pkg.sv
// Shared definitions for the decode/immediate stage: RV32 base opcodes,
// the instruction format enumeration and the decoded-field bundle that
// travels through the stage registers.
package decode_pkg;

    // RV32 base opcodes; bits [1:0] are always 2'b11 for 32-bit encodings
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // Everything decoded from the instruction word except the immediate
    // and PC, whose widths follow XLEN and are held alongside this bundle.
    typedef struct packed {
        fmt_e       fmt;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [6:0] opcode;
        logic       illegal;
    } dec_fields_t;

    // Map a full 7-bit opcode to its encoding format. Any word whose low
    // two bits are not 2'b11 cannot match a listed opcode, so it lands on
    // FMT_ILL without a separate check.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OPC_LUI,
            OPC_AUIPC:    f = FMT_U;
            OPC_JAL:      f = FMT_J;
            OPC_BRANCH:   f = FMT_B;
            OPC_STORE:    f = FMT_S;
            OPC_JALR,
            OPC_LOAD,
            OPC_OP_IMM,
            OPC_SYSTEM,
            OPC_MISC_MEM: f = FMT_I;
            OPC_OP:       f = FMT_R;
            default:      f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Purely combinational RV32 field decode and immediate extraction.
// Immediates are assembled at 32 bits and sign-extended to XLEN.
module imm_extract
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    output logic [XLEN-1:0]  imm,
    output dec_fields_t      fields
);

    fmt_e               fmt;
    logic signed [31:0] imm32;

    assign fmt = opcode_fmt(instr[6:0]);

    // Split the raw word into its register and function fields
    always_comb begin
        fields         = '0;
        fields.fmt     = fmt;
        fields.rd      = instr[11:7];
        fields.rs1     = instr[19:15];
        fields.rs2     = instr[24:20];
        fields.funct3  = instr[14:12];
        fields.funct7  = instr[31:25];
        fields.opcode  = instr[6:0];
        fields.illegal = (fmt == FMT_ILL);
    end

    // Reassemble the format-specific immediate bit scatter into 32 bits
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast replicates bit 31 up to XLEN (no-op at XLEN=32)
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_imm_stage.sv
// Decode/immediate pipeline stage: one output register plus one skid
// entry behind a valid/ready handshake on each side. in_ready is a
// register, so there is no combinational path from out_ready to in_ready.
// Optional macro DECODE_PERF_CNT_EN adds saturating transfer counters
// cnt_decoded and cnt_illegal.
module decode_imm_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [6:0]       out_opcode,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_decoded,
    output logic [CNT_W-1:0] cnt_illegal
`endif
);

    if (!((XLEN == 32) || (XLEN == 64)) || (CNT_W < 1)) begin : g_bad_param
        $error("decode_imm_stage: XLEN must be 32 or 64 and CNT_W at least 1");
    end

    dec_fields_t      dec_fields;
    logic [XLEN-1:0]  dec_imm;

    dec_fields_t      out_fields_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [XLEN-1:0]  out_pc_q;
    logic             out_valid_q;

    dec_fields_t      skid_fields_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [XLEN-1:0]  skid_pc_q;
    logic             skid_full_q;

    logic             in_ready_q;

    logic             in_fire;
    logic             out_fire;
    logic             load_from_skid;
    logic             load_from_in;
    logic             load_skid;
    logic             out_valid_d;
    logic             skid_full_d;

    imm_extract #(
        .XLEN (XLEN)
    ) u_imm_extract (
        .instr  (in_instr),
        .imm    (dec_imm),
        .fields (dec_fields)
    );

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Choose where this edge's data goes. The skid entry only fills while
    // the output is held, and in_ready is low whenever it is full, so a
    // full skid never coincides with a new input.
    always_comb begin
        load_from_skid = 1'b0;
        load_from_in   = 1'b0;
        load_skid      = 1'b0;
        out_valid_d    = out_valid_q;
        skid_full_d    = skid_full_q;
        if (!out_valid_q || out_ready) begin
            if (skid_full_q) begin
                load_from_skid = 1'b1;
                out_valid_d    = 1'b1;
                skid_full_d    = 1'b0;
            end else if (in_fire) begin
                load_from_in   = 1'b1;
                out_valid_d    = 1'b1;
            end else begin
                out_valid_d    = 1'b0;
            end
        end else if (in_fire) begin
            load_skid   = 1'b1;
            skid_full_d = 1'b1;
        end
    end

    // Occupancy flags; in_ready is held low through reset and rises one
    // cycle after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= !skid_full_d;
        end
    end

    // Output register: refilled from the skid entry first to keep order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_fields_q <= '0;
            out_imm_q    <= '0;
            out_pc_q     <= '0;
        end else if (load_from_skid) begin
            out_fields_q <= skid_fields_q;
            out_imm_q    <= skid_imm_q;
            out_pc_q     <= skid_pc_q;
        end else if (load_from_in) begin
            out_fields_q <= dec_fields;
            out_imm_q    <= dec_imm;
            out_pc_q     <= in_pc;
        end
    end

    // Skid entry captures an input accepted while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_fields_q <= '0;
            skid_imm_q    <= '0;
            skid_pc_q     <= '0;
        end else if (load_skid) begin
            skid_fields_q <= dec_fields;
            skid_imm_q    <= dec_imm;
            skid_pc_q     <= in_pc;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign out_fmt     = out_fields_q.fmt;
    assign out_rd      = out_fields_q.rd;
    assign out_rs1     = out_fields_q.rs1;
    assign out_rs2     = out_fields_q.rs2;
    assign out_funct3  = out_fields_q.funct3;
    assign out_funct7  = out_fields_q.funct7;
    assign out_opcode  = out_fields_q.opcode;
    assign out_illegal = out_fields_q.illegal;

`ifdef DECODE_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_decoded_q;
    logic [CNT_W-1:0] cnt_illegal_q;

    // Count output transfers, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_decoded_q <= '0;
            cnt_illegal_q <= '0;
        end else if (out_fire) begin
            if (cnt_decoded_q != '1) begin
                cnt_decoded_q <= cnt_decoded_q + 1'b1;
            end
            if (out_fields_q.illegal && (cnt_illegal_q != '1)) begin
                cnt_illegal_q <= cnt_illegal_q + 1'b1;
            end
        end
    end

    assign cnt_decoded = cnt_decoded_q;
    assign cnt_illegal = cnt_illegal_q;
`endif

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: drives an XLEN=32 and an XLEN=64 instance
// with identical stimulus and compares both against a queue-based model
// with an arithmetic immediate decoder.
module tb_decode_imm_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32, pc32;
    logic [2:0]  fmt32, f3_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [6:0]  f7_32, opc32;

    logic        rdy64, ov64, ill64;
    logic [63:0] imm64, pc64;
    logic [2:0]  fmt64, f3_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [6:0]  f7_64, opc64;

`ifdef DECODE_PERF_CNT_EN
    logic [3:0]  cd32, ci32, cd64, ci64;
`endif

    always #5 clk = ~clk;

    decode_imm_stage #(.XLEN(32), .CNT_W(4)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov32),
        .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
        .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_funct3(f3_32), .out_funct7(f7_32), .out_opcode(opc32),
        .out_pc(pc32), .out_illegal(ill32)
`ifdef DECODE_PERF_CNT_EN
        , .cnt_decoded(cd32), .cnt_illegal(ci32)
`endif
    );

    decode_imm_stage #(.XLEN(64), .CNT_W(4)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov64),
        .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
        .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_funct3(f3_64), .out_funct7(f7_64), .out_opcode(opc64),
        .out_pc(pc64), .out_illegal(ill64)
`ifdef DECODE_PERF_CNT_EN
        , .cnt_decoded(cd64), .cnt_illegal(ci64)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    item_t q[$];
    bit    m_ready;
    int    m_cd;
    int    m_ci;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] imm;
        bit          chk_regs;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    // Reference decoder: format from the opcode table, immediate as a
    // signed integer built from the field positions with shifts and masks
    function automatic void ref_decode(input logic [31:0] ins, output int fmt, output longint imm);
        longint u;
        longint v;
        u = longint'(ins);
        v = 0;
        case (ins & 32'h7F)
            32'h37, 32'h17:                         fmt = 4;
            32'h6F:                                 fmt = 5;
            32'h63:                                 fmt = 3;
            32'h23:                                 fmt = 2;
            32'h67, 32'h03, 32'h13, 32'h73, 32'h0F: fmt = 1;
            32'h33:                                 fmt = 0;
            default:                                fmt = 7;
        endcase
        case (fmt)
            1: begin
                v = u >> 20;
                if (v >= 2048) v -= 4096;
            end
            2: begin
                v = ((u >> 25) << 5) | ((u >> 7) & 31);
                if (v >= 2048) v -= 4096;
            end
            3: begin
                v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                    (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
                if (v >= 4096) v -= 8192;
            end
            4: begin
                v = u & 64'hFFFF_F000;
                if (v >= 64'h8000_0000) v -= 64'h1_0000_0000;
            end
            5: begin
                v = (((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                    (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
                if (v >= 64'h10_0000) v -= 64'h20_0000;
            end
            default: v = 0;
        endcase
        imm = v;
    endfunction

    task automatic check_outputs();
        int          f;
        longint      v;
        logic [63:0] vv;
        logic [31:0] ins;
        chk("in_ready32", rdy32, m_ready);
        chk("in_ready64", rdy64, m_ready);
        chk("out_valid32", ov32, q.size() > 0);
        chk("out_valid64", ov64, q.size() > 0);
        if (q.size() > 0) begin
            ins = q[0].instr;
            ref_decode(ins, f, v);
            vv = v;
            chk("imm32", imm32, vv & 64'hFFFF_FFFF);
            chk("imm64", imm64, vv);
            chk("fmt32", fmt32, f);
            chk("fmt64", fmt64, f);
            chk("illegal32", ill32, f == 7);
            chk("illegal64", ill64, f == 7);
            chk("rd", rd32, (ins >> 7) & 31);
            chk("rs1", rs1_32, (ins >> 15) & 31);
            chk("rs2", rs2_64, (ins >> 20) & 31);
            chk("funct3", f3_32, (ins >> 12) & 7);
            chk("funct7", f7_64, ins >> 25);
            chk("opcode", opc32, ins & 32'h7F);
            chk("pc32", pc32, q[0].pc & 64'hFFFF_FFFF);
            chk("pc64", pc64, q[0].pc);
        end
`ifdef DECODE_PERF_CNT_EN
        chk("cnt_decoded32", cd32, m_cd);
        chk("cnt_illegal32", ci32, m_ci);
        chk("cnt_decoded64", cd64, m_cd);
        chk("cnt_illegal64", ci64, m_ci);
`endif
    endtask

    task automatic check_reset_zero();
        chk("rst_out_valid", ov32 | ov64, 0);
        chk("rst_in_ready", rdy32 | rdy64, 0);
        chk("rst_imm", imm64 | imm32, 0);
        chk("rst_pc", pc64 | pc32, 0);
        chk("rst_fields", {fmt32, rd32, rs1_32, rs2_32, f3_32, f7_32, opc32, ill32}, 0);
        chk("rst_fields64", {fmt64, rd64, rs1_64, rs2_64, f3_64, f7_64, opc64, ill64}, 0);
    endtask

    // One clock: update the model at the rising edge, check at the falling
    task automatic cycle();
        bit     inf;
        bit     outf;
        int     f;
        longint v;
        inf  = in_valid && m_ready && !rst;
        outf = (q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ready = 0;
            m_cd = 0;
            m_ci = 0;
        end else begin
            if (outf) begin
                ref_decode(q[0].instr, f, v);
                if (m_cd < 15) m_cd++;
                if (f == 7 && m_ci < 15) m_ci++;
                void'(q.pop_front());
            end
            if (inf) q.push_back('{in_instr, in_pc});
            m_ready = q.size() < 2;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        m_ready = 0;
        m_cd = 0;
        m_ci = 0;
        check_outputs();
        check_reset_zero();
    endtask

    logic [31:0] seq_i[3];
    logic [63:0] seq_pc[3];
    int          acc;
    int          seen_pc[$];
    int          seen_at[$];
    logic [6:0]  legal_opc[11];
    logic [31:0] r;
    logic [63:0] tmp;

    initial begin
        vt[0]  = '{32'h00750193, 3'd1, 64'd7,                  1'b1, 5'd3,  5'd10, 5'd7};
        vt[1]  = '{32'hFE552FA3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 5'd10, 5'd5};
        vt[2]  = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 5'd0,  5'd0,  5'd0};
        vt[3]  = '{32'h0080006F, 3'd5, 64'd8,                  1'b0, 5'd0,  5'd0,  5'd0};
        vt[4]  = '{32'h0000007F, 3'd7, 64'd0,                  1'b0, 5'd0,  5'd0,  5'd0};
        vt[5]  = '{32'h12345037, 3'd4, 64'h0000_0000_1234_5000, 1'b0, 5'd0,  5'd0,  5'd0};
        vt[6]  = '{32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0, 5'd0,  5'd0,  5'd0};
        vt[7]  = '{32'h003100B3, 3'd0, 64'd0,                  1'b1, 5'd1,  5'd2,  5'd3};
        vt[8]  = '{32'h00000011, 3'd7, 64'd0,                  1'b0, 5'd0,  5'd0,  5'd0};
        vt[9]  = '{32'hFFC42283, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 5'd5,  5'd8,  5'd28};
        vt[10] = '{32'hFFFFF017, 3'd4, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 5'd0,  5'd0,  5'd0};
        vt[11] = '{32'h7FF00067, 3'd1, 64'd2047,               1'b0, 5'd0,  5'd0,  5'd0};
        vt[12] = '{32'h0000005B, 3'd7, 64'd0,                  1'b0, 5'd0,  5'd0,  5'd0};
        vt[13] = '{32'h00001463, 3'd3, 64'd8,                  1'b0, 5'd0,  5'd0,  5'd0};
        vt[14] = '{32'hFFDFF06F, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 5'd0,  5'd0,  5'd0};
        vt[15] = '{32'h00552423, 3'd2, 64'd8,                  1'b0, 5'd0,  5'd0,  5'd0};

        legal_opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                      7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        m_cd      = 0;
        m_ci      = 0;

        // Reset state
        do_reset();
        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Directed decode vectors, one at a time with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_instr = vt[i].instr;
            in_pc    = {$urandom, $urandom};
            cycle();
            in_valid = 1'b0;
            tmp = vt[i].imm;
            chk("vec_valid", ov32 & ov64, 1);
            chk("vec_fmt32", fmt32, vt[i].fmt);
            chk("vec_fmt64", fmt64, vt[i].fmt);
            chk("vec_imm32", imm32, tmp & 64'hFFFF_FFFF);
            chk("vec_imm64", imm64, tmp);
            chk("vec_illegal", ill32, vt[i].fmt == 3'd7);
            if (vt[i].chk_regs) begin
                chk("vec_rd", rd32, vt[i].rd);
                chk("vec_rs1", rs1_64, vt[i].rs1);
                chk("vec_rs2", rs2_32, vt[i].rs2);
            end
            cycle();
        end

        // Stall: three back-to-back offers with out_ready low
        seq_i  = '{32'h00750193, 32'hFE552FA3, 32'h0080006F};
        seq_pc = '{64'h100, 64'h104, 64'h108};
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (acc < 3);
            in_instr = seq_i[acc % 3];
            in_pc    = seq_pc[acc % 3];
            if (in_valid && m_ready) acc++;
            cycle();
        end
        chk("stall_accepted", acc, 2);
        chk("stall_in_ready", rdy32 | rdy64, 0);
        chk("stall_hold_pc", pc32, 32'h100);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (ov32) begin
                seen_pc.push_back(int'(pc32));
                seen_at.push_back(c);
            end
            in_valid = (acc < 3);
            in_instr = seq_i[acc % 3];
            in_pc    = seq_pc[acc % 3];
            if (in_valid && m_ready) acc++;
            cycle();
        end
        in_valid = 1'b0;
        chk("drain_count", seen_pc.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < seen_pc.size()) begin
                chk("drain_order", seen_pc[k], seq_pc[k]);
                chk("drain_cycle", seen_at[k], k);
            end
        end

        // Illegal first, then reset with two bundles held
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (acc < 2);
            in_instr = (acc == 0) ? 32'h0000007F : 32'h00750193;
            in_pc    = 64'h200 + 64'(acc * 4);
            if (in_valid && m_ready) acc++;
            cycle();
        end
        in_valid = 1'b0;
        chk("held_two", acc, 2);
        chk("held_illegal32", ill32, 1);
        chk("held_illegal64", ill64, 1);
        chk("held_fmt", fmt32, 7);
        do_reset();
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("post_rst_not_ready", rdy32 | rdy64, 0);
        @(negedge clk);
        cycle();
        chk("post_rst_ready", rdy32 & rdy64, 1);
        chk("post_rst_valid", ov32 | ov64, 0);
`ifdef DECODE_PERF_CNT_EN
        chk("post_rst_cnt", {cd32, ci32, cd64, ci64}, 0);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0) || (c >= 2000 && c < 2300);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                r[6:0] = legal_opc[$urandom_range(0, 10)];
            end
            in_instr = r;
            in_pc    = {$urandom, $urandom};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_imm_stage.md
DECODE_IMM_STAGE -- requirements
Module: decode_imm_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-high.
REQ-005 Port in_valid, input, 1, upstream offers an instruction.
REQ-006 Port in_ready, output, 1, stage can accept an instruction this cycle.
REQ-007 Port in_instr, input, 32, raw RV32 instruction word.
REQ-008 Port in_pc, input, XLEN, PC of in_instr.
REQ-009 Port out_valid, output, 1, decoded bundle valid.
REQ-010 Port out_ready, input, 1, downstream accepts the bundle.
REQ-011 Port out_imm, output, XLEN, sign-extended immediate.
REQ-012 Port out_fmt, output, 3, format code (R/I/S/B/U/J/ILL).
REQ-013 Ports out_rd, out_rs1, out_rs2, output, 5 each, register fields.
REQ-014 Ports out_funct3 (3), out_funct7 (7), out_opcode (7), output, raw fields.
REQ-015 Port out_pc, output, XLEN, PC travelling with the bundle.
REQ-016 Port out_illegal, output, 1, opcode unrecognised or instr[1:0] != 2'b11.

Function
REQ-017 A transfer occurs on valid && ready at each port; no other condition moves data.
REQ-018 Latency SHALL be exactly 1 cycle from input transfer to out_valid when the output register is empty.
REQ-019 Storage SHALL be an output register plus one skid entry; in_ready = !skid_full, a registered signal with no combinational path from out_ready.
REQ-020 When out_ready=0 and the output register is occupied, an accepted input goes to the skid entry; the output holds stable while out_valid=1 && !out_ready.
REQ-021 When the output transfers, the skid entry (if full) moves to the output in the same edge; otherwise the new input (if any) loads directly.
REQ-022 Order SHALL be strictly FIFO; no bundle is dropped or duplicated; simultaneous in/out transfers are lossless.
REQ-023 Formats: LUI/AUIPC=U; JAL=J; BRANCH=B; STORE=S; JALR/LOAD/OP-IMM/SYSTEM/MISC-MEM=I; OP=R; anything else=ILL.
REQ-024 Immediates: I={i[31:20]}, S={i[31:25],i[11:7]}, B={i[31],i[7],i[30:25],i[11:8],0}, J={i[31],i[19:12],i[20],i[30:21],0}, each sign-extended from bit 31 to XLEN.
REQ-025 U={i[31:12],12'b0}, sign-extended to XLEN when XLEN=64; R and ILL produce out_imm=0.
REQ-026 out_illegal=1 iff out_fmt=ILL; the bundle still transfers normally.

Reset
REQ-027 While rst=1: out_valid=0, skid empty, in_ready=0, counters 0; all data outputs 0.
REQ-028 The cycle after rst deasserts, in_ready=1; any in-flight bundles are discarded, not replayed.

Configuration
REQ-029 Macro DECODE_PERF_CNT_EN: when defined, add outputs cnt_decoded and cnt_illegal (CNT_W each), incremented on each output transfer (illegal ones on cnt_illegal too), saturating at all-ones.
REQ-030 When DECODE_PERF_CNT_EN is undefined, these ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-031 Package decode_pkg SHALL hold the opcode localparams, the fmt_e enum (R=0,I=1,S=2,B=3,U=4,J=5,ILL=7) and the decoded-bundle struct.
REQ-032 Combinational decode and immediate extraction SHALL be sub-module imm_extract (parameter XLEN); decode_imm_stage owns only handshake and storage.

Verification
REQ-033 ADDI 0x00750193 with out_ready=1 -> the next cycle shows out_valid=1, fmt=I, imm=7, rd=3, rs1=10.
REQ-034 SW 0xFE552FA3 -> fmt=S, imm=0xFFFFFFFF (XLEN=32), rs1=10, rs2=5.
REQ-035 BEQ 0xFE000EE3 at XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC; JAL 0x0080006F -> fmt=J, imm=8.
REQ-036 out_ready=0 with three instructions offered back-to-back -> two are accepted, then in_ready=0 and the output stays stable; release out_ready -> the instructions drain in order, one per cycle.
REQ-037 0x0000007F, then rst asserted mid-stream with two bundles held -> out_illegal=1 for the first; after reset out_valid=0, in_ready=1 a cycle later, and with DECODE_PERF_CNT_EN both counters read 0.
